// File: rtl/cost_port_arbiter_pkg.sv
// Shared definitions for the cost-port arbiter and the JAM search engine.
package cost_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam int NUM_WORKERS = 8;
  localparam int IDX_W       = 3;
  localparam int COST_W      = 7;
  localparam int BURST_LEN   = 8;
  localparam logic [IDX_W-1:0] LAST_BEAT = 3'(BURST_LEN - 1);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

endpackage

// File: rtl/cost_port_arbiter.sv
// Two-requester burst arbiter for a single combinational cost-table port.
// Optional per-requester burst statistics are enabled with COST_ARB_STATS_EN.
module cost_port_arbiter
  import cost_port_arbiter_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              req0,
  input  logic              req1,
  input  logic [IDX_W-1:0]  w0,
  input  logic [IDX_W-1:0]  j0,
  input  logic [IDX_W-1:0]  w1,
  input  logic [IDX_W-1:0]  j1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [COST_W-1:0] rdata,
  output logic [IDX_W-1:0]  W,
  output logic [IDX_W-1:0]  J,
`ifdef COST_ARB_STATS_EN
  output logic [15:0]       bursts0,
  output logic [15:0]       bursts1,
`endif
  input  logic [COST_W-1:0] Cost
);

  arb_state_e       state_r;
  arb_state_e       next_own_s;
  logic [IDX_W-1:0] beat_r;
  logic             last_owner_r;
  logic             issue0_s;
  logic             issue1_s;
  logic             own_s;
  logic             own_req_s;
  logic             oth_req_s;
  logic             burst_end_s;

  assign gnt0 = (state_r == OWN0);
  assign gnt1 = (state_r == OWN1);

  // Lookup address and burst-end / hand-over decision for the current owner
  always_comb begin
    issue0_s    = 1'b0;
    issue1_s    = 1'b0;
    W           = {IDX_W{1'b0}};
    J           = {IDX_W{1'b0}};
    own_s       = (state_r == OWN1);
    own_req_s   = own_s ? req1 : req0;
    oth_req_s   = own_s ? req0 : req1;
    burst_end_s = (state_r != IDLE) && (!own_req_s || (beat_r == LAST_BEAT));
    next_own_s  = IDLE;
    if ((state_r == OWN0) && req0) begin
      issue0_s = 1'b1;
      W        = w0;
      J        = j0;
    end else if ((state_r == OWN1) && req1) begin
      issue1_s = 1'b1;
      W        = w1;
      J        = j1;
    end else begin
      W = {IDX_W{1'b0}};
      J = {IDX_W{1'b0}};
    end
    // The other requester gets priority at a burst boundary
    if (oth_req_s) begin
      next_own_s = own_s ? OWN0 : OWN1;
    end else if (own_req_s) begin
      next_own_s = own_s ? OWN1 : OWN0;
    end else begin
      next_own_s = IDLE;
    end
  end

  // Ownership FSM, beat counter and registered response
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r      <= IDLE;
      beat_r       <= {IDX_W{1'b0}};
      last_owner_r <= 1'b1;
      rvalid0      <= 1'b0;
      rvalid1      <= 1'b0;
      rdata        <= {COST_W{1'b0}};
    end else begin
      rvalid0 <= issue0_s;
      rvalid1 <= issue1_s;
      if (issue0_s || issue1_s) begin
        rdata <= Cost;
      end
      case (state_r)
        IDLE: begin
          if (req0 && (!req1 || last_owner_r)) begin
            state_r <= OWN0;
          end else if (req1) begin
            state_r <= OWN1;
          end else begin
            state_r <= IDLE;
          end
        end
        OWN0, OWN1: begin
          if (burst_end_s) begin
            state_r      <= next_own_s;
            beat_r       <= {IDX_W{1'b0}};
            last_owner_r <= own_s;
          end else begin
            beat_r <= beat_r + 3'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          beat_r  <= {IDX_W{1'b0}};
        end
      endcase
    end
  end

`ifdef COST_ARB_STATS_EN
  // Saturating completed-burst counters per requester
  always_ff @(posedge CLK) begin
    if (RST) begin
      bursts0 <= 16'd0;
      bursts1 <= 16'd0;
    end else if (burst_end_s) begin
      if (own_s) begin
        bursts1 <= sat_inc16(bursts1);
      end else begin
        bursts0 <= sat_inc16(bursts0);
      end
    end
  end
`endif

endmodule

// File: doc/cost_port_arbiter.md
COST_PORT_ARBITER -- requirements
Module: cost_port_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: CLK (rising edge) and RST, both inputs, 1 bit.
REQ-002 The requester inputs SHALL be:
- req0, req1: input, 1 bit, requester k wants a cost lookup this cycle.
- w0, j0, w1, j1: input, 3 bits each, worker and job index of requester k.
REQ-003 The grant and response outputs SHALL be:
- gnt0, gnt1: output, 1 bit, requester k owns the cost port this cycle.
- rvalid0, rvalid1: output, 1 bit, rdata holds requester k's result.
- rdata: output, 7 bits, registered Cost value shared by both requesters.
REQ-004 The cost-table side SHALL be:
- W, J: output, 3 bits, lookup address driven to the cost table.
- Cost: input, 7 bits, combinational table response to W/J in the same cycle.

Function
REQ-005 The block SHALL contain a state register with three states: IDLE, OWN0 and OWN1.
REQ-006 The grant outputs SHALL be decoded from the state register only: gnt0=(state==OWN0), gnt1=(state==OWN1).
REQ-007 A lookup for requester k SHALL be issued in any cycle where state==OWNk and req_k=1.
- W and J SHALL be driven with wk and jk.
- In every other cycle W and J SHALL be 0.
REQ-008 In the cycle after a lookup for requester k, rdata SHALL equal the Cost sampled with that lookup, and rvalid_k SHALL be 1.
- Latency is exactly 1 cycle.
- rvalid0 and rvalid1 SHALL never be high together.
REQ-009 rdata SHALL hold its last value when no lookup was issued in the previous cycle.
REQ-010 A 3-bit beat counter SHALL increment on each issued lookup; a burst is 8 lookups, matching one full 8-worker assignment.
REQ-011 In IDLE, the next state SHALL be chosen as follows:
- Only req0 set: go to OWN0.
- Only req1 set: go to OWN1.
- Both set: grant the requester that is not last_owner.
- Neither set: stay in IDLE.
- No lookup is issued in IDLE.
REQ-012 In OWNk, a burst SHALL end in either of two cases:
- req_k=1 and the beat counter is 7: the 8th lookup is issued.
- req_k=0: no lookup is issued that cycle.
REQ-013 When a burst ends, the next state SHALL be chosen as follows:
- Go to OWN(other) if req_other=1.
- Otherwise go to OWNk if req_k=1, starting a new burst.
- Otherwise go to IDLE.
- In all three cases, clear the beat counter and set last_owner=k.
REQ-014 While state==OWNk and the burst has not ended, a request from the other requester SHALL be ignored; preemption is not permitted.
REQ-015 Worst-case grant latency for a continuously asserted request SHALL be 9 cycles: one full 8-lookup burst by the other requester plus one cycle.
REQ-016 w/j inputs of the non-owning requester SHALL have no effect on any output.

Reset
REQ-017 On RST=1 at a clock edge, the block SHALL enter the following reset values:
- state=IDLE, beat counter=0, last_owner=1 (so req0 wins the first tie).
- rvalid0=rvalid1=0, rdata=0, W=J=0.
REQ-018 RST asserted mid-burst SHALL abort the burst, with no rvalid in the following cycle; lookups issued before reset are not replayed.

Configuration
REQ-019 When macro COST_ARB_STATS_EN is defined, the block SHALL add outputs bursts0 and bursts1 (16 bits each).
- Each counter SHALL count completed bursts for its requester, both 8-beat and early-release.
- Each counter SHALL saturate at 65535 and reset to 0.
REQ-020 When COST_ARB_STATS_EN is undefined, the stats ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-021 A shared package SHALL hold the following, to be reused by the JAM search engine:
- State encoding: IDLE=0, OWN0=1, OWN1=2.
- Constants: NUM_WORKERS=8, IDX_W=3, COST_W=7, BURST_LEN=8.
REQ-022 The arbiter SHALL be a single module with no sub-modules; the tie-break and next-owner logic is small enough to remain inline.

Verification
REQ-023 Single requester: req0 held 8 cycles with w0=0..7 and j0=7..0, table Cost=w*8+j.
- Required: gnt0 from cycle 1.
- Required: rvalid0 on cycles 2..9 with rdata=7,14,21,28,35,42,49,56.
- Required: return to IDLE.
REQ-024 Tie after reset: req0=req1=1 held.
- Required: OWN0 for 8 lookups, then OWN1 for 8 lookups, then OWN0.
- Required: no cycle has gnt0 and gnt1 both high.
REQ-025 Early release: req1 drops after 3 lookups while req0=1.
- Required: the next state is OWN0.
- Required: rvalid1 pulses exactly 3 times.
- Required: bursts1=1 when COST_ARB_STATS_EN is defined.
REQ-026 Reset mid-burst: RST pulsed after the 4th lookup of requester 0.
- Required: in the next cycle rvalid0=0, state=IDLE and W=J=0.
- Required: with both requesting afterwards, requester 0 is granted first.
REQ-027 Non-owner isolation: while OWN0, toggle w1/j1 randomly.
- Required: W, J and rdata track only requester 0.
- Required: rvalid1 stays 0.
